accel_cmd_driver: RTL and testbench

- Initiator side of the modular-arithmetic accelerator handshake: a memory-mapped register front-end for the CPU.
- Captures operands, modulus and op code, then drives the accelerator's a/b/modulant/control/start inputs.
- Waits for finished, captures result, and exposes busy/done/error status.
- Auto-sequences the mandatory R-setup before multiplication/exponentiation whenever the modulus has changed.

---
 rtl/accel_pkg.sv | 43 ++++
 rtl/accel_wait_timer.sv | 54 +++++
 rtl/accel_cmd_driver.sv | 192 +++++++++++++++++++
 tb/tb_accel_cmd_driver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types and constants for the modular-arithmetic accelerator command driver.
package accel_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_MOD    = 3'b010,
    OP_RSETUP = 3'b011,
    OP_MULT   = 3'b100,
    OP_EXP    = 3'b101
  } op_t;

  localparam logic [2:0] REG_A      = 3'd0;
  localparam logic [2:0] REG_B      = 3'd1;
  localparam logic [2:0] REG_MOD    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_RESULT = 3'd5;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_RVALID  = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_TIMEOUT = 4;

  localparam int GO_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RS_START,
    RS_WAIT,
    OP_START,
    OP_WAIT,
    DONE
  } drv_state_t;

  // Montgomery-style ops need the R constant loaded for the current modulus.
  function automatic logic needs_rsetup(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_EXP);
  endfunction

endpackage

// File: rtl/accel_wait_timer.sv
// Wait-state timer: settle window after each start pulse, plus an optional
// wait-state limit compiled in with ACCEL_TIMEOUT_EN.
module accel_wait_timer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic settle_done,
  output logic timeout
);

  localparam int SW = $clog2(SETTLE_CYCLES + 2);

  logic [SW-1:0] settle_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
    end else if (load) begin
      settle_q <= SW'(SETTLE_CYCLES);
    end else if (run && (settle_q != '0)) begin
      settle_q <= settle_q - SW'(1);
    end
  end

  assign settle_done = (settle_q == '0);

`ifdef ACCEL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] limit_q;

  // Loaded with limit-1 so the flag rises in the TIMEOUT_CYCLES-th wait cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q <= '0;
    end else if (load) begin
      limit_q <= TW'(TIMEOUT_CYCLES - 1);
    end else if (run && (limit_q != '0)) begin
      limit_q <= limit_q - TW'(1);
    end
  end

  assign timeout = run && (limit_q == '0);
`else
  // Feature compiled out; the parameter stays referenced so both builds share one interface.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: rtl/accel_cmd_driver.sv
// CPU register front-end that sequences operations on the modular accelerator.
// Optional wait-state timeout is enabled by defining ACCEL_TIMEOUT_EN.
module accel_cmd_driver
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [2:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [DATA_WIDTH-1:0] acc_a,
  output logic [DATA_WIDTH-1:0] acc_b,
  output logic [DATA_WIDTH-1:0] acc_modulant,
  output logic [2:0]            acc_control,
  output logic                  acc_start,
  input  logic [DATA_WIDTH-1:0] acc_result,
  input  logic                  acc_finished
);

  drv_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q, mod_q, result_q;
  logic [2:0] op_q, control_q, control_d;
  logic r_valid_q, done_q, err_q, timeout_q;
  logic busy, accept, go, needs_r, finish_seen;
  logic settle_done, timeout_hit, timer_load, timer_run;
  logic unused_wdata;

  assign busy        = state_q inside {CHECK, RS_START, RS_WAIT, OP_START, OP_WAIT};
  assign accept      = we && !busy;
  assign go          = accept && (addr == REG_CTRL) && wdata[GO_BIT];
  assign needs_r     = needs_rsetup(op_q);
  assign finish_seen = acc_finished && settle_done;
  // Bus bits above the stored fields have no destination.
  assign unused_wdata = ^wdata;

  assign acc_a        = a_q;
  assign acc_b        = b_q;
  assign acc_modulant = mod_q;
  assign acc_control  = control_q;
  assign acc_start    = (state_q == RS_START) || (state_q == OP_START);

  accel_wait_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .run        (timer_run),
    .settle_done(settle_done),
    .timeout    (timeout_hit)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    control_d  = control_q;
    timer_load = 1'b0;
    timer_run  = 1'b0;
    unique case (state_q)
      IDLE, DONE: state_d = go ? CHECK : IDLE;
      CHECK: begin
        if (needs_r && !mod_q[0]) begin
          state_d = DONE;
        end else if (needs_r && !r_valid_q) begin
          state_d   = RS_START;
          control_d = OP_RSETUP;
        end else begin
          state_d   = OP_START;
          control_d = op_q;
        end
      end
      RS_START: begin
        timer_load = 1'b1;
        state_d    = RS_WAIT;
      end
      // control stays at R-setup through the finish cycle so the accelerator latches R.
      RS_WAIT: begin
        timer_run = 1'b1;
        if (finish_seen) begin
          state_d   = OP_START;
          control_d = op_q;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      OP_START: begin
        timer_load = 1'b1;
        state_d    = OP_WAIT;
      end
      OP_WAIT: begin
        timer_run = 1'b1;
        if (finish_seen || timeout_hit) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      control_q <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      mod_q     <= '0;
      result_q  <= '0;
      op_q      <= '0;
      r_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;

      if (accept) begin
        case (addr)
          REG_A:    a_q  <= wdata[DATA_WIDTH-1:0];
          REG_B:    b_q  <= wdata[DATA_WIDTH-1:0];
          REG_MOD: begin
            mod_q     <= wdata[DATA_WIDTH-1:0];
            r_valid_q <= 1'b0;
          end
          REG_CTRL: op_q <= wdata[2:0];
          default: ;
        endcase
      end

      if (go) begin
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
      end

      // Status and result update on the transition into DONE.
      unique case (state_q)
        CHECK: begin
          if (needs_r && !mod_q[0]) begin
            err_q    <= 1'b1;
            result_q <= '0;
            done_q   <= 1'b1;
          end
        end
        RS_WAIT: begin
          if (finish_seen) begin
            r_valid_q <= 1'b1;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            result_q  <= '0;
            done_q    <= 1'b1;
          end
        end
        OP_WAIT: begin
          if (finish_seen) begin
            result_q <= acc_result;
            done_q   <= 1'b1;
            if (op_q == OP_RSETUP) r_valid_q <= 1'b1;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            result_q  <= '0;
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_A:      rdata[DATA_WIDTH-1:0] = a_q;
      REG_B:      rdata[DATA_WIDTH-1:0] = b_q;
      REG_MOD:    rdata[DATA_WIDTH-1:0] = mod_q;
      REG_RESULT: rdata[DATA_WIDTH-1:0] = result_q;
      REG_STATUS: begin
        rdata[ST_BUSY]    = busy;
        rdata[ST_DONE]    = done_q;
        rdata[ST_RVALID]  = r_valid_q;
        rdata[ST_ERR]     = err_q;
        rdata[ST_TIMEOUT] = timeout_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_accel_cmd_driver.sv
// Directed bench for accel_cmd_driver: table of operations against a behavioural
// accelerator responder, plus reset, busy-write and (with ACCEL_TIMEOUT_EN) timeout sequences.
module tb_accel_cmd_driver;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [2:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [DW-1:0] acc_a, acc_b, acc_modulant;
  logic [2:0]    acc_control;
  logic          acc_start;
  logic [DW-1:0] acc_result   = '0;
  logic          acc_finished = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  accel_cmd_driver #(
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .acc_a       (acc_a),
    .acc_b       (acc_b),
    .acc_modulant(acc_modulant),
    .acc_control (acc_control),
    .acc_start   (acc_start),
    .acc_result  (acc_result),
    .acc_finished(acc_finished)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural accelerator ----------------
  function automatic logic [7:0] acc_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] m);
    int r;
    if (m == 0) return 8'h00;
    case (op)
      3'd0: r = (int'(a) + int'(b)) % int'(m);
      3'd1: begin
        r = (int'(a) - int'(b)) % int'(m);
        if (r < 0) r = r + int'(m);
      end
      3'd2: r = int'(a) % int'(m);
      3'd3: r = 256 % int'(m);
      3'd4: r = (int'(a) * int'(b)) % int'(m);
      3'd5: begin
        r = 1;
        for (int i = 0; i < int'(b); i++) r = (r * int'(a)) % int'(m);
      end
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  function automatic int acc_latency(input logic [2:0] op);
    case (op)
      3'd2, 3'd3: return 4;
      3'd5:       return 6;
      default:    return 1;
    endcase
  endfunction

  int         n_starts = 0;
  logic [2:0] ctrl_log[$];
  bit         hold_stale = 1'b0;
  bit         mute = 1'b0;
  int         acc_cnt = 0;
  int         stale_left = 0;
  logic [7:0] pending = '0;

  // Finished stays high (stale) for a cycle or two after a start; the result bus
  // carries a poison value until the real finish, so an early capture is visible.
  always @(negedge clk) begin
    if (acc_start) begin
      n_starts++;
      ctrl_log.push_back(acc_control);
      pending    = acc_model(acc_control, acc_a, acc_b, acc_modulant);
      acc_result = 8'hEE;
      if (mute) begin
        acc_cnt      = 0;
        acc_finished = 1'b0;
      end else begin
        acc_cnt    = acc_latency(acc_control);
        stale_left = hold_stale ? 2 : 1;
      end
    end else if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) begin
        acc_result   = pending;
        acc_finished = 1'b1;
      end else begin
        acc_finished = (stale_left > 0);
        if (stale_left > 0) stale_left--;
      end
    end
  end

  // ---------------- bench helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    addr   = 3'd4;
    #1;
    while (!rdata[1] && cycles < budget) begin
      @(negedge clk);
      cycles++;
      #1;
    end
    if (!rdata[1]) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [7:0]  m, a, b;
    logic [2:0]  op;
    bit          wr_mod;
    bit          stale;
    logic [7:0]  exp_res;
    int          exp_starts;
    logic [2:0]  exp_ctrl0;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] d;
    int          cyc;
    int          s0;

    vecs[0] = '{8'd13, 8'd9,  8'd7, 3'd0, 1'b1, 1'b0, 8'd3, 1, 3'd0, 32'h02};
    vecs[1] = '{8'd13, 8'd3,  8'd7, 3'd1, 1'b1, 1'b0, 8'd9, 1, 3'd1, 32'h02};
    vecs[2] = '{8'd13, 8'd5,  8'd6, 3'd4, 1'b1, 1'b0, 8'd4, 2, 3'd3, 32'h06};
    vecs[3] = '{8'd13, 8'd5,  8'd6, 3'd4, 1'b0, 1'b0, 8'd4, 1, 3'd4, 32'h06};
    vecs[4] = '{8'd13, 8'd2,  8'd5, 3'd5, 1'b0, 1'b1, 8'd6, 1, 3'd5, 32'h06};
    vecs[5] = '{8'd12, 8'd5,  8'd6, 3'd4, 1'b1, 1'b0, 8'd0, 0, 3'd4, 32'h0A};
    vecs[6] = '{8'd11, 8'd4,  8'd9, 3'd0, 1'b1, 1'b0, 8'd2, 1, 3'd0, 32'h02};
    vecs[7] = '{8'd11, 8'd20, 8'd0, 3'd2, 1'b0, 1'b0, 8'd9, 1, 3'd2, 32'h02};
    vecs[8] = '{8'd11, 8'd0,  8'd0, 3'd3, 1'b0, 1'b0, 8'd3, 1, 3'd3, 32'h06};
    vecs[9] = '{8'd11, 8'd3,  8'd4, 3'd4, 1'b0, 1'b0, 8'd1, 1, 3'd4, 32'h06};

    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      check($sformatf("reset_reg%0d", i), d, 32'h0);
    end
    check("reset_start", {31'b0, acc_start}, 32'h0);
    check("reset_control", {29'b0, acc_control}, 32'h0);

    // Truncation, write-only CTRL, unmapped addresses
    @(negedge clk);
    wr(3'd0, 32'h0000_01FF);
    rd(3'd0, d);
    check("trunc_a", d, 32'h0000_00FF);
    wr(3'd3, 32'h0000_0005);
    rd(3'd3, d);
    check("ctrl_reads_0", d, 32'h0);
    rd(3'd4, d);
    check("no_go_status", d, 32'h0);
    wr(3'd6, 32'h1234_5678);
    rd(3'd6, d);
    check("reg6_reads_0", d, 32'h0);

    // Table-driven operations
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ctrl_log.delete();
      hold_stale = vecs[i].stale;
      s0 = n_starts;
      if (vecs[i].wr_mod) wr(3'd2, {24'b0, vecs[i].m});
      wr(3'd0, {24'b0, vecs[i].a});
      wr(3'd1, {24'b0, vecs[i].b});
      wr(3'd3, 32'h100 | {29'b0, vecs[i].op});
      wait_done(200, cyc);
      if (i == 0) check("latency_add", cyc, 5);
      rd(3'd5, d);
      check($sformatf("v%0d_result", i), d, {24'b0, vecs[i].exp_res});
      rd(3'd4, d);
      check($sformatf("v%0d_status", i), d, vecs[i].exp_status);
      check($sformatf("v%0d_starts", i), n_starts - s0, vecs[i].exp_starts);
      if (vecs[i].exp_starts > 0) begin
        check($sformatf("v%0d_ctrl_first", i), {29'b0, ctrl_log[0]}, {29'b0, vecs[i].exp_ctrl0});
        check($sformatf("v%0d_ctrl_last", i), {29'b0, ctrl_log[ctrl_log.size()-1]},
              {29'b0, vecs[i].op});
      end
      hold_stale = 1'b0;
    end

    // Reset in OP_WAIT
    @(negedge clk);
    wr(3'd2, 32'd13);
    wr(3'd0, 32'd9);
    wr(3'd1, 32'd7);
    wr(3'd3, 32'h100);
    @(negedge clk);
    check("opstart_pulse", {31'b0, acc_start}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(3'd4, d);
    check("midreset_status", d, 32'h0);
    rd(3'd5, d);
    check("midreset_result", d, 32'h0);
    rd(3'd0, d);
    check("midreset_a", d, 32'h0);
    check("midreset_start", {31'b0, acc_start}, 32'h0);
    check("midreset_control", {29'b0, acc_control}, 32'h0);

    // Writes while busy are ignored
    @(negedge clk);
    s0 = n_starts;
    wr(3'd2, 32'd13);
    wr(3'd0, 32'd9);
    wr(3'd1, 32'd7);
    wr(3'd3, 32'h100);
    wr(3'd3, 32'h101);
    wr(3'd0, 32'h55);
    wait_done(200, cyc);
    check("busy_starts", n_starts - s0, 1);
    rd(3'd5, d);
    check("busy_result", d, 32'd3);
    rd(3'd0, d);
    check("busy_a_kept", d, 32'd9);
    @(negedge clk);
    rd(3'd4, d);
    check("busy_idle_status", d, 32'h02);

`ifdef ACCEL_TIMEOUT_EN
    @(negedge clk);
    mute = 1'b1;
    wr(3'd2, 32'd13);
    wr(3'd3, 32'h100);
    wait_done(100, cyc);
    check("timeout_latency", cyc, 18);
    rd(3'd4, d);
    check("timeout_status", d, 32'h12);
    rd(3'd5, d);
    check("timeout_result", d, 32'h0);
    mute = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
